layer_stream_feeder: RTL
========================

Name: layer_stream_feeder

Overview:
- Sequential front/back end for a learning layer.
- Accepts one sample as a serial element stream, assembles the N-wide input vector and the M-wide target vector, and fires the layer for one cycle (forward, or forward+learn).
- Waits a fixed latency, captures the layer outputs, then streams them back out element by element.
- Sits between the sample source (memory/UART loader) and a neuron_learn layer instance.

Parameters:
- N, 16, layer input count (elements per input vector).
- M, 27, layer output count (elements per target/output vector).
- LAT, 1, cycles from layer_valid to layer_out being stable; legal range 1..15.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample element valid.
- s_ready  out  1  feeder accepts element.
- s_data  in  zero2one_t  sample element (inputs first, then targets).
- train  in  1  sampled with the first input element of a sample; 1 = targets follow and the layer learns.
- layer_in  out  zero2one_t [N]  assembled input vector to the layer.
- layer_expected_out  out  zero2one_t [M]  assembled target vector to the layer.
- layer_valid  out  1  one-cycle fire strobe to the layer.
- layer_learn  out  1  learn strobe, coincident with layer_valid.
- layer_out  in  zero2one_t [M]  layer forward outputs.
- m_valid  out  1  result element valid.
- m_ready  in  1  downstream accepts result element.
- m_data  out  zero2one_t  result element.
- m_last  out  1  marks element M-1 of the result.
- busy  out  1  high in every state except LOAD_IN with in_cnt==0.

Behaviour:
- State machine: LOAD_IN, LOAD_TGT, FIRE, WAIT, DRAIN. Reset state is LOAD_IN.
- Reset values: all outputs 0; in_cnt, tgt_cnt, wait_cnt and out_cnt are 0; the vector and capture registers are 0.
- An element is accepted when s_valid && s_ready.
- s_ready is 1 only in LOAD_IN and LOAD_TGT. It is a registered function of state and is not combinationally dependent on s_valid.
- LOAD_IN:
  - Each accepted element writes layer_in[in_cnt], then in_cnt increments.
  - train is latched into train_q on the accept with in_cnt==0.
  - On accepting element N-1: go to LOAD_TGT if train_q (or train, if N==1) is set, else go to FIRE. in_cnt clears.
- LOAD_TGT:
  - Each accepted element writes layer_expected_out[tgt_cnt], then tgt_cnt increments.
  - On accepting element M-1, go to FIRE.
  - In a non-train sample, layer_expected_out keeps its previous contents.
- FIRE:
  - Lasts exactly one cycle.
  - layer_valid=1; layer_learn=train_q.
  - layer_in and layer_expected_out are stable from FIRE through the end of WAIT.
  - Next state is WAIT, with wait_cnt=LAT-1.
- WAIT:
  - wait_cnt decrements each cycle.
  - In the cycle wait_cnt==0, capture layer_out into cap[M] and go to DRAIN.
  - Latency from the FIRE cycle to capture is LAT cycles.
- DRAIN:
  - m_valid=1; m_data=cap[out_cnt]; m_last=(out_cnt==M-1).
  - On m_valid && m_ready, out_cnt increments.
  - On accepting element M-1, return to LOAD_IN.
  - m_valid/m_data/m_last are held unchanged while m_ready=0.
- Downstream handshake: m_valid never drops without a handshake. No new sample is accepted until DRAIN completes; there is no overlap between samples.
- Back-to-back:
  - The first element of the next sample can be accepted in the cycle after the last m handshake.
  - Minimum sample period is N + (train?M:0) + 1 + LAT + M cycles.
- Reset mid-operation: reset_n low at any point aborts immediately to reset values. A partially loaded sample is discarded, any pending layer strobe is withdrawn, and m_valid drops.
- Counter widths are $clog2(N+1), $clog2(M+1), and 4 bits (wait_cnt). Counters never exceed N-1 / M-1 / LAT-1.
- s_valid asserted in FIRE/WAIT/DRAIN is ignored (s_ready=0). The source must hold it.

Optional Feature:
- Macro: FEEDER_ERR_EN.
- Defined:
  - In a train sample, the capture stores |layer_out[i] - layer_expected_out[i]| (unsigned, exact, same zero2one_t width) instead of layer_out[i].
  - Non-train samples are unchanged.
- Undefined: the capture always stores layer_out.
- Port list and timing are identical in both builds.

Decomposition:
- defs.svh gains feeder_state_t (5-state enum).
- zero2one_t comes from the existing defs.svh.
- One sub-module: zero2one_absdiff (combinational |a-b|), instantiated M times under FEEDER_ERR_EN only.

Test Plan:
- Forward only (N=16, M=27, LAT=1, train=0):
  - Stimulus: feed elements 'h00..'h0F; the layer model echoes layer_out[i]='h10+i.
  - Check: exactly one layer_valid pulse with layer_learn=0.
  - Check: m stream returns 'h10..'h2A, m_last on the 27th element.
- Train sample:
  - Stimulus: 16 inputs followed by 27 targets 'h80.
  - Check: layer_expected_out is all 'h80 at FIRE and layer_learn=1.
  - Check: 43 accepts precede FIRE.
- Backpressure:
  - Stimulus: m_ready toggles 1/0 every cycle during DRAIN.
  - Check: m_data/m_last are stable while m_ready=0.
  - Check: exactly 27 handshakes, no duplicates.
- LAT=3:
  - Stimulus: the layer model changes layer_out at FIRE+1 and FIRE+2; its final value is stable at FIRE+3.
  - Check: the captured value equals the FIRE+3 value.
- Reset mid-DRAIN:
  - Stimulus: assert reset_n=0 after 5 m handshakes.
  - Check: m_valid=0 and busy=0 immediately.
  - Check: the next sample loads from in_cnt=0 correctly.
- FEEDER_ERR_EN build:
  - Stimulus: target 'h40, layer_out 'h70.
  - Check: m_data='h30; a non-train sample returns the raw 'h70.

Source files
------------

// File: rtl/layer_stream_feeder_pkg.sv
// Shared types for the layer stream feeder: element type and feeder FSM states.
package layer_stream_feeder_pkg;

  localparam int Z2O_W = 8;

  // Unsigned fixed-point value in [0,1).
  typedef logic [Z2O_W-1:0] zero2one_t;

  typedef enum logic [2:0] {
    ST_LOAD_IN,
    ST_LOAD_TGT,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN
  } feeder_state_t;

endpackage

// File: rtl/zero2one_absdiff.sv
// Per-element |a-b| for the error-capture option (FEEDER_ERR_EN).
// Only compiled when the option is enabled, so the default build has no
// stray top-level module.
`ifdef FEEDER_ERR_EN
module zero2one_absdiff
  import layer_stream_feeder_pkg::*;
(
  input  zero2one_t a,
  input  zero2one_t b,
  output zero2one_t y
);

  // Exact unsigned distance, no wrap.
  always_comb y = (a >= b) ? zero2one_t'(a - b) : zero2one_t'(b - a);

endmodule
`endif

// File: rtl/layer_stream_feeder.sv
// Serial sample loader / result drainer around one learning layer.
// Assembles N inputs (+M targets when training), fires the layer for one
// cycle, waits LAT cycles, captures the outputs and streams them back.
// FEEDER_ERR_EN: in train samples, capture |layer_out - target| instead.
module layer_stream_feeder
  import layer_stream_feeder_pkg::*;
#(
  parameter int N   = 16,
  parameter int M   = 27,
  parameter int LAT = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  zero2one_t           s_data,
  input  logic                train,
  output zero2one_t [N-1:0]   layer_in,
  output zero2one_t [M-1:0]   layer_expected_out,
  output logic                layer_valid,
  output logic                layer_learn,
  input  zero2one_t [M-1:0]   layer_out,
  output logic                m_valid,
  input  logic                m_ready,
  output zero2one_t           m_data,
  output logic                m_last,
  output logic                busy
);

  localparam int IW = $clog2(N+1);
  localparam int OW = $clog2(M+1);
  localparam logic [IW-1:0] IN_LAST  = IW'(N-1);
  localparam logic [OW-1:0] OUT_LAST = OW'(M-1);

  feeder_state_t      state;
  logic [IW-1:0]      in_cnt;
  logic [OW-1:0]      tgt_cnt, out_cnt, nxt_idx;
  logic [3:0]         wait_cnt;
  logic               train_q, eff_train, s_acc, m_acc;
  zero2one_t [M-1:0]  cap, cap_src;
  zero2one_t          nxt_data;

  assign s_acc     = s_valid && s_ready;
  assign m_acc     = m_valid && m_ready;
  // train is only valid alongside the first input element.
  assign eff_train = (in_cnt == '0) ? train : train_q;

`ifdef FEEDER_ERR_EN
  zero2one_t [M-1:0] err;
  zero2one_absdiff u_absdiff [M-1:0] (.a(layer_out), .b(layer_expected_out), .y(err));
  assign cap_src = train_q ? err : layer_out;
`else
  assign cap_src = layer_out;
`endif

  // Next drain element, preloaded so m_data stays a plain register.
  always_comb begin
    nxt_idx  = out_cnt + 1'b1;
    nxt_data = '0;
    for (int i = 0; i < M; i++)
      if (nxt_idx == OW'(i)) nxt_data = cap[i];
  end

  // Feeder FSM with registered handshake and strobe outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_LOAD_IN;
      in_cnt             <= '0;
      tgt_cnt            <= '0;
      out_cnt            <= '0;
      wait_cnt           <= '0;
      train_q            <= 1'b0;
      cap                <= '0;
      layer_in           <= '0;
      layer_expected_out <= '0;
      layer_valid        <= 1'b0;
      layer_learn        <= 1'b0;
      s_ready            <= 1'b0;
      m_valid            <= 1'b0;
      m_data             <= '0;
      m_last             <= 1'b0;
      busy               <= 1'b0;
    end else begin
      layer_valid <= 1'b0;
      layer_learn <= 1'b0;
      case (state)
        ST_LOAD_IN: begin
          s_ready <= 1'b1;
          if (s_acc) begin
            for (int i = 0; i < N; i++)
              if (in_cnt == IW'(i)) layer_in[i] <= s_data;
            if (in_cnt == '0) train_q <= train;
            busy <= 1'b1;
            if (in_cnt == IN_LAST) begin
              in_cnt <= '0;
              if (eff_train) begin
                state <= ST_LOAD_TGT;
              end else begin
                state       <= ST_FIRE;
                s_ready     <= 1'b0;
                layer_valid <= 1'b1;
              end
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_TGT: begin
          s_ready <= 1'b1;
          if (s_acc) begin
            for (int i = 0; i < M; i++)
              if (tgt_cnt == OW'(i)) layer_expected_out[i] <= s_data;
            if (tgt_cnt == OUT_LAST) begin
              tgt_cnt     <= '0;
              state       <= ST_FIRE;
              s_ready     <= 1'b0;
              layer_valid <= 1'b1;
              layer_learn <= train_q;
            end else begin
              tgt_cnt <= tgt_cnt + 1'b1;
            end
          end
        end
        ST_FIRE: begin
          state    <= ST_WAIT;
          wait_cnt <= 4'(LAT-1);
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            cap     <= cap_src;
            state   <= ST_DRAIN;
            m_valid <= 1'b1;
            m_data  <= cap_src[0];
            m_last  <= (M == 1);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_acc) begin
            if (out_cnt == OUT_LAST) begin
              out_cnt <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= ST_LOAD_IN;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end else begin
              out_cnt <= nxt_idx;
              m_data  <= nxt_data;
              m_last  <= (nxt_idx == OUT_LAST);
            end
          end
        end
        default: state <= ST_LOAD_IN;
      endcase
    end
  end

endmodule
